// File: rtl/mul_datapath_pkg.sv
// Shared constants for the shift-add multiplier datapath.
// Default operand width, derived counter and product widths.
package mul_datapath_pkg;

  localparam int W_DEF = 4;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

  localparam int NW_DEF = cnt_w(W_DEF);
  localparam int PW_DEF = prod_w(W_DEF);

endpackage

// File: rtl/mul_datapath_if.sv
// Bundle of operand, micro-op strobe and condition signals.
// master drives operands/strobes; slave is the datapath side.
interface mul_datapath_if
  import mul_datapath_pkg::*;
#(
  parameter int W = W_DEF
);
  logic [W-1:0]   a_in;
  logic [W-1:0]   b_in;
  logic           t1;
  logic           t2;
  logic           t3;
  logic           t4;
  logic           ta;
  logic           x;
  logic           y;
  logic           z;
  logic [2*W-1:0] prod;
  logic           done;

  modport master (
    output a_in, b_in, t1, t2, t3, t4, ta,
    input  x, y, z, prod, done
  );

  modport slave (
    input  a_in, b_in, t1, t2, t3, t4, ta,
    output x, y, z, prod, done
  );
endinterface

// File: rtl/mul_loop_counter.sv
// Loop counter: loads W, decrements and saturates at zero.
// Ports: clk, res (async low), load, dec -> nz (count != 0).
module mul_loop_counter
  import mul_datapath_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic clk,
  input  logic res,
  input  logic load,
  input  logic dec,
  output logic nz
);
  localparam int NW = cnt_w(W);

  logic [NW-1:0] n_q;
  logic [NW-1:0] n_d;

  // load wins over a same-cycle decrement
  always_comb begin
    n_d = n_q;
    unique case (1'b1)
      load:                n_d = NW'(W);
      dec && (n_q != '0):  n_d = n_q - 1'b1;
      default:             n_d = n_q;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) n_q <= '0;
    else      n_q <= n_d;
  end

  assign nz = (n_q != '0);

endmodule

// File: rtl/mul_datapath.sv
// Shift-add multiplier datapath driven by micro-op strobes.
// Ports: operands a_in/b_in, strobes t1..t4/ta -> x,y,z,prod,done.
module mul_datapath
  import mul_datapath_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic           clk,
  input  logic           res,
  input  logic [W-1:0]   a_in,
  input  logic [W-1:0]   b_in,
  input  logic           t1,
  input  logic           t2,
  input  logic           t3,
  input  logic           t4,
  input  logic           ta,
  output logic           x,
  output logic           y,
  output logic           z,
  output logic [2*W-1:0] prod,
  output logic           done
);
  localparam int PW = prod_w(W);

  logic [PW-1:0] a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [PW-1:0] p_q, p_d;
  logic          ov_q, ov_d;
  logic [PW-1:0] prod_q, prod_d;
  logic          done_q, done_d;
  logic [PW:0]   sum;

  // carry-out of the accumulate feeds the sticky overflow
  assign sum = {1'b0, p_q} + {1'b0, a_q};

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    p_d    = p_q;
    ov_d   = ov_q;
    prod_d = prod_q;
    done_d = ta;
    if (t1) begin
      a_d  = {{W{1'b0}}, a_in};
      b_d  = b_in;
      p_d  = '0;
      ov_d = 1'b0;
    end else begin
      if (t3) begin
        p_d  = sum[PW-1:0];
        ov_d = ov_q | sum[PW];
      end
      if (t4) begin
        a_d = a_q << 1;
        b_d = b_q >> 1;
      end
    end
    if (ta) prod_d = p_q;
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      a_q    <= '0;
      b_q    <= '0;
      p_q    <= '0;
      ov_q   <= 1'b0;
      prod_q <= '0;
      done_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      p_q    <= p_d;
      ov_q   <= ov_d;
      prod_q <= prod_d;
      done_q <= done_d;
    end
  end

  mul_loop_counter #(.W(W)) u_cnt (
    .clk  (clk),
    .res  (res),
    .load (t2),
    .dec  (t4),
    .nz   (x)
  );

  assign y    = b_q[0];
  assign z    = ov_q;
  assign prod = prod_q;
  assign done = done_q;

endmodule

// File: tb/tb_mul_datapath.sv
// Directed bench for mul_datapath, W=4.
// Hand-computed vectors; single check task.
module tb_mul_datapath;
  import mul_datapath_pkg::*;

  localparam int W = 4;

  logic clk;
  logic res;
  int   n_chk;
  int   n_fail;

  mul_datapath_if #(.W(W)) bus ();

  mul_datapath #(.W(W)) dut (
    .clk  (clk),
    .res  (res),
    .a_in (bus.a_in),
    .b_in (bus.b_in),
    .t1   (bus.t1),
    .t2   (bus.t2),
    .t3   (bus.t3),
    .t4   (bus.t4),
    .ta   (bus.ta),
    .x    (bus.x),
    .y    (bus.y),
    .z    (bus.z),
    .prod (bus.prod),
    .done (bus.done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // s = {t1,t2,t3,t4,ta}; one clock, outputs settled on return
  task automatic cyc(input logic [4:0] s);
    {bus.t1, bus.t2, bus.t3, bus.t4, bus.ta} = s;
    @(posedge clk);
    #1;
    {bus.t1, bus.t2, bus.t3, bus.t4, bus.ta} = '0;
  endtask

  task automatic run(input logic [3:0] a, input logic [3:0] b,
                     output int n_t3, output int y_hi);
    bus.a_in = a;
    bus.b_in = b;
    n_t3 = 0;
    y_hi = 0;
    cyc(5'b10000);
    cyc(5'b01000);
    for (int i = 0; i < W; i++) begin
      if (bus.y) begin
        n_t3++;
        y_hi++;
        cyc(5'b00110);
      end else begin
        cyc(5'b00010);
      end
    end
    cyc(5'b00001);
  endtask

  int nt, yh;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    res    = 1'b0;
    bus.a_in = '0;
    bus.b_in = '0;
    {bus.t1, bus.t2, bus.t3, bus.t4, bus.ta} = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_x", 32'(bus.x), 0);
    check("rst_y", 32'(bus.y), 0);
    check("rst_z", 32'(bus.z), 0);
    check("rst_prod", 32'(bus.prod), 0);
    check("rst_done", 32'(bus.done), 0);
    res = 1'b1;

    // 13 * 11
    run(4'd13, 4'd11, nt, yh);
    check("m13x11_prod", 32'(bus.prod), 143);
    check("m13x11_done", 32'(bus.done), 1);
    check("m13x11_x", 32'(bus.x), 0);
    check("m13x11_z", 32'(bus.z), 0);
    check("m13x11_nt3", 32'(nt), 3);
    cyc(5'b00000);
    check("m13x11_done0", 32'(bus.done), 0);
    check("m13x11_hold", 32'(bus.prod), 143);

    // 15 * 0: no accumulate ever
    run(4'd15, 4'd0, nt, yh);
    check("m15x0_prod", 32'(bus.prod), 0);
    check("m15x0_yhi", 32'(yh), 0);
    check("m15x0_z", 32'(bus.z), 0);

    // overflow wrap: 18 * 15 = 270 -> 14
    bus.a_in = 4'd15;
    bus.b_in = 4'd0;
    cyc(5'b10000);
    repeat (17) cyc(5'b00100);
    check("ov_17_z", 32'(bus.z), 0);
    cyc(5'b00100);
    check("ov_18_z", 32'(bus.z), 1);
    cyc(5'b00001);
    check("ov_wrap", 32'(bus.prod), 14);
    cyc(5'b00010);
    check("ov_sticky", 32'(bus.z), 1);
    cyc(5'b10000);
    check("ov_clr", 32'(bus.z), 0);

    // counter saturation
    cyc(5'b01000);
    check("cnt_load", 32'(bus.x), 1);
    repeat (3) cyc(5'b00010);
    check("cnt_3", 32'(bus.x), 1);
    cyc(5'b00010);
    check("cnt_4", 32'(bus.x), 0);
    cyc(5'b00010);
    check("cnt_5", 32'(bus.x), 0);
    cyc(5'b00000);
    check("cnt_hold", 32'(bus.x), 0);

    // t1 overrides t3/t4
    bus.a_in = 4'd5;
    bus.b_in = 4'd3;
    cyc(5'b10110);
    check("ovr_y", 32'(bus.y), 1);
    cyc(5'b00001);
    check("ovr_p", 32'(bus.prod), 0);
    cyc(5'b00110);
    check("t34_y", 32'(bus.y), 1);
    cyc(5'b00001);
    check("t34_p", 32'(bus.prod), 5);
    cyc(5'b00100);
    cyc(5'b00101);
    check("t34_a10", 32'(bus.prod), 15);
    cyc(5'b00001);
    check("ta_pre_t3", 32'(bus.prod), 25);

    // async reset mid-iteration
    bus.a_in = 4'd9;
    bus.b_in = 4'd7;
    cyc(5'b10000);
    cyc(5'b01000);
    cyc(5'b00110);
    #2;
    res = 1'b0;
    #1;
    check("arst_x", 32'(bus.x), 0);
    check("arst_y", 32'(bus.y), 0);
    check("arst_prod", 32'(bus.prod), 0);
    check("arst_done", 32'(bus.done), 0);
    @(posedge clk);
    #3;
    res = 1'b1;
    cyc(5'b00000);
    check("arst_idle_x", 32'(bus.x), 0);
    check("arst_idle_y", 32'(bus.y), 0);
    run(4'd6, 4'd7, nt, yh);
    check("m6x7_prod", 32'(bus.prod), 42);
    check("m6x7_z", 32'(bus.z), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1);
  end

endmodule

// File: doc/mul_datapath.md
MUL_DATAPATH -- requirements
Module: mul_datapath

Interface
REQ-001 Parameter: W, 4, operand width in bits (legal 2..8).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 res  input  1  reset, asynchronous, active-low (res=0 resets immediately, independent of clk).
REQ-004 a_in  input  W  multiplicand, sampled on t1.
REQ-005 b_in  input  W  multiplier, sampled on t1.
REQ-006 t1  input  1  micro-op strobe: init operands and product.
REQ-007 t2  input  1  micro-op strobe: load loop counter.
REQ-008 t3  input  1  micro-op strobe: accumulate P <= P + A.
REQ-009 t4  input  1  micro-op strobe: shift A left, shift B right, decrement counter.
REQ-010 ta  input  1  micro-op strobe: publish result.
REQ-011 x  output  1  condition: loop counter N != 0.
REQ-012 y  output  1  condition: B[0].
REQ-013 z  output  1  condition: sticky accumulate overflow.
REQ-014 prod  output  2W  published product.
REQ-015 done  output  1  one-cycle pulse, the cycle after ta is sampled.

Function
REQ-016 Registers SHALL be: A (2W bits), B (W bits), P (2W bits), N (ceil(log2(W+1)) bits), OV (1 bit), prod (2W bits), done (1 bit).
REQ-017 All next-state values SHALL be computed from current register values; all asserted strobes in one cycle apply simultaneously.
REQ-018 t1: A <= zero-extended a_in, B <= b_in, P <= 0, OV <= 0; t1 SHALL override t3 and t4 on A, B, P, OV.
REQ-019 t2: N <= W; t2 SHALL override t4 on N.
REQ-020 t3 (without t1): P <= (P + A) mod 2^(2W); OV <= OV | carry-out of that addition.
REQ-021 t4 (without t1): A <= A << 1 (MSB discarded), B <= B >> 1 (zero fill); N <= N - 1 unless t2 or N == 0 (N saturates at 0).
REQ-022 t3 and t4 together: P uses the pre-shift A.
REQ-023 ta: prod <= current P (value before any same-cycle t3 update); done = 1 for exactly the next cycle, then 0 unless ta is sampled again.
REQ-024 No strobe asserted: every register holds.
REQ-025 x, y, z SHALL be combinational decodes of registers only (Moore): x = (N != 0), y = B[0], z = OV; no combinational path from any input to any output.
REQ-026 Full sequence t1, t2, then W iterations of {t3 if y}+t4, then ta SHALL yield prod = a_in * b_in exactly, z = 0.

Reset
REQ-027 While res = 0: A, B, P, N, OV, prod = 0; done = 0; hence x = 0, y = 0, z = 0.
REQ-028 Reset mid-sequence SHALL abandon the operation; after release, the block holds until the next t1/t2.
REQ-029 Strobes in the first edge after res deasserts SHALL be honoured normally.

Structure
REQ-030 Shared package SHALL hold default W, the derived counter width, and the 2W product width constant.
REQ-031 Loop counter (load W, saturating decrement, nonzero flag) SHALL be one sub-module: mul_loop_counter.
REQ-032 Expected RTL size 120-300 lines; no latches, no gated clocks.

Verification
REQ-033 W=4, a_in=13, b_in=11, canonical sequence (REQ-026) -> prod = 143, done pulses once, x = 0 at end, z = 0.
REQ-034 a_in=15, b_in=0, canonical sequence -> y = 0 in every iteration, no t3 issued, prod = 0.
REQ-035 After t1 with a_in=15, 18 consecutive t3 -> P wraps (270 mod 256 = 14), z = 1 and stays 1 until next t1.
REQ-036 t2 then 5 t4 -> x falls after the 4th t4, N holds 0 after the 5th, no underflow.
REQ-037 Same-cycle t1+t3+t4 with a_in=5, b_in=3 -> A = 5, B = 3, P = 0 next cycle; same-cycle t3+t4 with A=5 -> P += 5, A = 10.
REQ-038 res pulled low mid-iteration (between clk edges) -> all outputs 0 immediately; t1, t2 after release with 6*7 -> prod = 42.
